imm_encoder: RTL and testbench

- Inverse of the immediate extractor. Accepts instruction-field requests (opcode, registers, funct fields, full 32-bit immediate) and packs the immediate back into the RV32I bit positions for the opcode's format.
- Emits 32-bit instruction words with a load address for the instruction-memory loader / self-test program generator.
- Valid/ready on both sides, 2-entry skid buffering, sequential address counter.

---
 rtl/imm_encoder_pkg.sv | 43 ++++
 rtl/imm_encoder_pack.sv | 48 ++++
 rtl/imm_encoder.sv | 139 +++++++++++++
 tb/tb_imm_encoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: RV32I opcode constants, instruction-format codes and the
// word record carried through the encoder's output buffering.
package imm_encoder_pkg;

    // RV32I opcodes that carry an immediate
    localparam logic [6:0] Itype_J = 7'b1100111; // JALR
    localparam logic [6:0] Itype_L = 7'b0000011; // loads
    localparam logic [6:0] Itype_A = 7'b0010011; // ALU immediate
    localparam logic [6:0] Utype_A = 7'b0010111; // AUIPC
    localparam logic [6:0] Utype_L = 7'b0110111; // LUI
    localparam logic [6:0] Jtype_J = 7'b1101111; // JAL
    localparam logic [6:0] Btype   = 7'b1100011; // branches
    localparam logic [6:0] Stype   = 7'b0100011; // stores

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R
    } fmt_e;

    // One emitted word with its load address and range flag
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } inst_word_t;

    // Anything not recognised as an immediate format is packed as R-type
    function automatic fmt_e opcode_fmt(input logic [6:0] op);
        case (op)
            Itype_J, Itype_L, Itype_A: opcode_fmt = FMT_I;
            Stype:                     opcode_fmt = FMT_S;
            Btype:                     opcode_fmt = FMT_B;
            Utype_A, Utype_L:          opcode_fmt = FMT_U;
            Jtype_J:                   opcode_fmt = FMT_J;
            default:                   opcode_fmt = FMT_R;
        endcase
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: combinational opcode-to-format decode and RV32I immediate packing.
// With IMM_RANGE_CHK_EN defined, o_err flags immediates the format cannot
// represent; otherwise o_err is tied low and excess bits are dropped.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_inst,
    output logic        o_err
);

    fmt_e w_fmt;

    // Scatter the immediate into the bit positions of the decoded format
    always_comb begin
        w_fmt  = opcode_fmt(i_opcode);
        o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        o_err  = 1'b0;
        case (w_fmt)
            FMT_I: o_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            FMT_S: o_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            FMT_B: o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
            FMT_U: o_inst = {i_imm[31:12], i_rd, i_opcode};
            FMT_J: o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                             i_rd, i_opcode};
            default: ;
        endcase
`ifdef IMM_RANGE_CHK_EN
        // Sign-extension bits above the field must all match; B/J also need
        // an even offset since bit 0 is implicit
        case (w_fmt)
            FMT_I, FMT_S: o_err = !((&i_imm[31:11]) || !(|i_imm[31:11]));
            FMT_B:        o_err = !((&i_imm[31:12]) || !(|i_imm[31:12])) || i_imm[0];
            FMT_J:        o_err = !((&i_imm[31:20]) || !(|i_imm[31:20])) || i_imm[0];
            FMT_U:        o_err = |i_imm[11:0];
            default:      o_err = 1'b0;
        endcase
`endif
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: packs instruction-field requests into RV32I words and emits
// them with sequential load addresses. Output register plus one skid
// register; request ready is registered. Optional range check is enabled
// by defining IMM_RANGE_CHK_EN (see imm_pack).
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [6:0]  req_opcode_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [6:0]  req_funct7_i,
    input  logic [31:0] req_imm_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_err_o,
    output logic        full_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             r_out_valid;
    inst_word_t       r_out;
    logic             r_skid_valid;
    inst_word_t       r_skid;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_req_ready;

    logic [31:0]      w_inst;
    logic             w_err;
    inst_word_t       w_new;
    logic             w_accept;
    logic             w_last;
    logic             w_out_free;
    logic             w_out_load_new;
    logic             w_out_load_skid;
    logic             w_skid_load;
    logic             w_out_valid_nxt;
    logic             w_skid_valid_nxt;
    logic             w_full_nxt;

    imm_pack u_pack (
        .i_opcode (req_opcode_i),
        .i_rd     (req_rd_i),
        .i_rs1    (req_rs1_i),
        .i_rs2    (req_rs2_i),
        .i_funct3 (req_funct3_i),
        .i_funct7 (req_funct7_i),
        .i_imm    (req_imm_i),
        .o_inst   (w_inst),
        .o_err    (w_err)
    );

    assign w_new    = '{inst: w_inst, addr: r_addr, err: w_err};
    assign w_accept = req_valid_i && r_req_ready;
    assign w_last   = (r_count == CNT_W'(DEPTH - 1));

    // Steer the accepted word into output or skid; ready is only high with
    // the skid empty, so an accept never collides with a skid refill
    always_comb begin
        w_out_free       = !r_out_valid || inst_ready_i;
        w_out_load_new   = 1'b0;
        w_out_load_skid  = 1'b0;
        w_skid_load      = 1'b0;
        w_out_valid_nxt  = r_out_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_full_nxt       = r_full || (w_accept && w_last);
        if (w_accept) begin
            if (w_out_free) begin
                w_out_load_new  = 1'b1;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_skid_load      = 1'b1;
                w_skid_valid_nxt = 1'b1;
            end
        end else if (r_out_valid && inst_ready_i) begin
            if (r_skid_valid) begin
                w_out_load_skid  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end
    end

    // Buffer, address counter and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out        <= '{inst: 32'h0, addr: BASE_ADDR, err: 1'b0};
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
            r_addr       <= BASE_ADDR;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_req_ready  <= 1'b1;
        end else if (restart_i) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_req_ready  <= 1'b1;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_full       <= w_full_nxt;
            r_req_ready  <= !w_skid_valid_nxt && !w_full_nxt;
            if (w_out_load_new)  r_out  <= w_new;
            if (w_out_load_skid) r_out  <= r_skid;
            if (w_skid_load)     r_skid <= w_new;
            if (w_accept) begin
                r_addr  <= r_addr + 32'd4;
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign req_ready_o  = r_req_ready;
    assign inst_valid_o = r_out_valid;
    assign inst_o       = r_out.inst;
    assign inst_addr_o  = r_out.addr;
    assign inst_err_o   = r_out.err;
    assign full_o       = r_full;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed scenarios plus randomized traffic against an
// arithmetic encoding model and a queue-based view of the output buffer.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [6:0]  req_opcode_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic [4:0]  req_rs1_i = '0;
    logic [4:0]  req_rs2_i = '0;
    logic [2:0]  req_funct3_i = '0;
    logic [6:0]  req_funct7_i = '0;
    logic [31:0] req_imm_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_err_o;
    logic        full_o;

    imm_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .restart_i    (restart_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_opcode_i (req_opcode_i),
        .req_rd_i     (req_rd_i),
        .req_rs1_i    (req_rs1_i),
        .req_rs2_i    (req_rs2_i),
        .req_funct3_i (req_funct3_i),
        .req_funct7_i (req_funct7_i),
        .req_imm_i    (req_imm_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_err_o   (inst_err_o),
        .full_o       (full_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   acc_cnt = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
`ifdef IMM_RANGE_CHK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference encoder: shifts/masks from the ISA field map, signed ranges
    function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] imm);
        logic [31:0]        w;
        logic               e;
        logic signed [31:0] s;
        logic [31:0]        regs;
        s    = imm;
        regs = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
        case (op)
            Itype_J, Itype_L, Itype_A: begin
                w = regs | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
                e = (s < -2048) || (s > 2047);
            end
            Stype: begin
                w = regs | (32'(rs2) << 20) | ((imm & 32'h1F) << 7) | (((imm >> 5) & 32'h7F) << 25);
                e = (s < -2048) || (s > 2047);
            end
            Btype: begin
                w = regs | (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8)
                  | (((imm >> 11) & 32'h1) << 7) | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 12) & 32'h1) << 31);
                e = (s < -4096) || (s > 4095) || ((imm % 2) != 0);
            end
            Utype_A, Utype_L: begin
                w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
                e = (imm % 4096) != 0;
            end
            Jtype_J: begin
                w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                  | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 20) & 32'h1) << 31);
                e = (s < -(1 << 20)) || (s > (1 << 20) - 1) || ((imm % 2) != 0);
            end
            default: begin
                w = regs | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
                e = 1'b0;
            end
        endcase
        return {e & CHK_ON, w};
    endfunction

    // B-type immediate extraction, for the round-trip check
    function automatic logic [31:0] b_extract(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    task automatic check_outputs();
        chk("valid", 32'(inst_valid_o), 32'(q.size() > 0));
        chk("ready", 32'(req_ready_o), 32'(q.size() < 2 && acc_cnt < DEPTH));
        chk("full",  32'(full_o), 32'(acc_cnt >= DEPTH));
        if (q.size() > 0) begin
            chk("inst", inst_o, q[0].inst);
            chk("addr", inst_addr_o, q[0].addr);
            chk("err",  32'(inst_err_o), 32'(q[0].err));
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge
    task automatic cycle(input bit rv, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm,
                         input bit ir, input bit rs, input bit do_rst);
        bit          exp_ready;
        logic [32:0] m;
        exp_t        x;
        req_valid_i = rv;  req_opcode_i = op; req_rd_i = rd; req_rs1_i = rs1;
        req_rs2_i = rs2;   req_funct3_i = f3; req_funct7_i = f7; req_imm_i = imm;
        inst_ready_i = ir; restart_i = rs;    rst = do_rst;
        if (do_rst || rs) begin
            q.delete();
            acc_cnt = 0;
        end else begin
            exp_ready = (q.size() < 2) && (acc_cnt < DEPTH);
            if (q.size() > 0 && ir) void'(q.pop_front());
            if (rv && exp_ready) begin
                m = model(op, rd, rs1, rs2, f3, f7, imm);
                x.inst = m[31:0];
                x.err  = m[32];
                x.addr = BASE + 32'(4 * acc_cnt);
                q.push_back(x);
                acc_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit ir);
        cycle(1'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, ir, 1'b0, 1'b0);
    endtask

    task automatic restart();
        cycle(1'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send(input logic [6:0] op, input logic [31:0] imm, input bit ir);
        cycle(1'b1, op, 5'd1, 5'd3, 5'd5, 3'd2, 7'h20, imm, ir, 1'b0, 1'b0);
    endtask

    logic [6:0] ops [9] = '{Itype_J, Itype_L, Itype_A, Utype_A, Utype_L,
                            Jtype_J, Btype, Stype, 7'b0110011};

    initial begin
        logic [31:0] imm;
        logic [6:0]  op;
        cycle(1'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_addr", inst_addr_o, BASE);

        // Round trip through a B-type encode/extract
        cycle(1'b1, Btype, 5'd0, 5'd3, 5'd5, 3'd0, 7'h0, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
        chk("rt_inst", inst_o, 32'hFE51_8CE3);
        chk("rt_imm", b_extract(inst_o), 32'hFFFF_FFF8);
        // LUI, one-cycle latency
        cycle(1'b1, Utype_L, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1234_5000, 1'b1, 1'b0, 1'b0);
        chk("lui_inst", inst_o, 32'h1234_50B7);

        // Range flags
        restart();
        cycle(1'b1, Itype_A, 5'd1, 5'd2, 5'd0, 3'd0, 7'h0, 32'h0000_0800, 1'b1, 1'b0, 1'b0);
        chk("rng_i_err", 32'(inst_err_o), 32'(CHK_ON));
        chk("rng_i_imm", 32'(inst_o[31:20]), 32'h800);
        cycle(1'b1, Jtype_J, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3, 1'b1, 1'b0, 1'b0);
        chk("rng_j_err", 32'(inst_err_o), 32'(CHK_ON));

        // Backpressure: third request held until the skid drains
        restart();
        send(Itype_A, 32'd1, 1'b0);
        chk("bp_rdy1", 32'(req_ready_o), 32'd1);
        send(Itype_A, 32'd2, 1'b0);
        chk("bp_rdy2", 32'(req_ready_o), 32'd0);
        send(Itype_A, 32'd3, 1'b0);
        chk("bp_addr0", inst_addr_o, BASE);
        send(Itype_A, 32'd3, 1'b1);
        chk("bp_addr1", inst_addr_o, BASE + 32'd4);
        send(Itype_A, 32'd3, 1'b1);
        chk("bp_addr2", inst_addr_o, BASE + 32'd8);
        idle(1'b1);

        // Full after DEPTH accepts, fifth request held off
        restart();
        for (int i = 0; i < 4; i++) send(Stype, 32'(i * 4), 1'b1);
        chk("full_set", 32'(full_o), 32'd1);
        chk("full_addr", inst_addr_o, BASE + 32'd12);
        send(Stype, 32'd100, 1'b1);
        chk("full_hold", 32'(req_ready_o), 32'd0);
        idle(1'b1);

        // Restart with output stalled and skid occupied
        restart();
        send(Utype_A, 32'h0000_3000, 1'b0);
        send(Utype_A, 32'h0000_4000, 1'b0);
        cycle(1'b1, Itype_L, 5'd1, 5'd1, 5'd1, 3'd0, 7'h0, 32'd8, 1'b1, 1'b1, 1'b0);
        chk("rs_valid", 32'(inst_valid_o), 32'd0);
        chk("rs_full", 32'(full_o), 32'd0);
        send(Itype_L, 32'd8, 1'b0);
        chk("rs_addr", inst_addr_o, BASE);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            op = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: imm = 32'($signed(12'($urandom)));
                1: imm = 32'($signed(13'($urandom))) & ~32'h1;
                2: imm = $urandom & 32'hFFFF_F000;
                default: imm = $urandom;
            endcase
            cycle(($urandom_range(0, 9) < 7), op, 5'($urandom), 5'($urandom), 5'($urandom),
                  3'($urandom), 7'($urandom), imm, ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 99) < 2), ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
